// File: rtl/video_stream_sink.sv
// Terminating sink for the 12-bit ready/valid/SOP/EOP video stream.
// Tracks framing and reports per-frame length, checksum and framing errors.
module video_stream_sink #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int READY_MODE   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        startofpacket_in,
    input  logic        endofpacket_in,
    input  logic [11:0] data_in,
    output logic        ready_out,
    output logic [31:0] pixel_count_out,
    output logic        frame_done,
    output logic [31:0] frame_pixels,
    output logic [23:0] frame_checksum,
    output logic        frame_err_len,
    output logic        frame_err_sop,
    output logic [15:0] frames_total,
    output logic [15:0] drop_count
);
    localparam logic [31:0] FRAME_LEN = 32'(IMAGE_WIDTH * IMAGE_HEIGHT);

    typedef enum logic {IDLE, RECV} state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] count_q, count_d;
    logic [23:0] sum_q, sum_d;
    logic        restart_q, restart_d;
    logic        done_q, done_d;
    logic [31:0] fpix_q, fpix_d;
    logic [23:0] fsum_q, fsum_d;
    logic        ferr_len_q, ferr_len_d;
    logic        ferr_sop_q, ferr_sop_d;
    logic [15:0] ftot_q, ftot_d;
    logic [15:0] drop_q, drop_d;

    logic        beat;
    logic        close;
    logic [31:0] nxt_cnt;
    logic [23:0] nxt_sum;
    logic        nxt_rst;

    assign beat = valid_in & ready_q;

    always_comb begin
        ready_d    = (READY_MODE == 1) ? ~ready_q : 1'b1;
        state_d    = state_q;
        count_d    = count_q;
        sum_d      = sum_q;
        restart_d  = restart_q;
        done_d     = 1'b0;
        fpix_d     = fpix_q;
        fsum_d     = fsum_q;
        ferr_len_d = ferr_len_q;
        ferr_sop_d = ferr_sop_q;
        ftot_d     = ftot_q;
        drop_d     = drop_q;
        close      = 1'b0;
        nxt_cnt    = count_q;
        nxt_sum    = sum_q;
        nxt_rst    = restart_q;

        if (beat) begin
            if (startofpacket_in) begin
                // SOP always starts a fresh frame; inside RECV it abandons the old one
                nxt_cnt = 32'd1;
                nxt_sum = {12'd0, data_in};
                nxt_rst = (state_q == RECV);
                close   = endofpacket_in;
                state_d = RECV;
            end else if (state_q == IDLE) begin
                if (drop_q != 16'hFFFF)
                    drop_d = drop_q + 16'd1;
            end else begin
                nxt_cnt = count_q + 32'd1;
                nxt_sum = sum_q + {12'd0, data_in};
                close   = endofpacket_in;
            end

            count_d   = nxt_cnt;
            sum_d     = nxt_sum;
            restart_d = nxt_rst;

            if (close) begin
                done_d     = 1'b1;
                fpix_d     = nxt_cnt;
                fsum_d     = nxt_sum;
                ferr_len_d = (nxt_cnt != FRAME_LEN);
                ferr_sop_d = nxt_rst;
                ftot_d     = ftot_q + 16'd1;
                count_d    = 32'd0;
                sum_d      = 24'd0;
                restart_d  = 1'b0;
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            count_q    <= 32'd0;
            sum_q      <= 24'd0;
            restart_q  <= 1'b0;
            done_q     <= 1'b0;
            fpix_q     <= 32'd0;
            fsum_q     <= 24'd0;
            ferr_len_q <= 1'b0;
            ferr_sop_q <= 1'b0;
            ftot_q     <= 16'd0;
            drop_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            restart_q  <= restart_d;
            done_q     <= done_d;
            fpix_q     <= fpix_d;
            fsum_q     <= fsum_d;
            ferr_len_q <= ferr_len_d;
            ferr_sop_q <= ferr_sop_d;
            ftot_q     <= ftot_d;
            drop_q     <= drop_d;
        end
    end

    assign ready_out       = ready_q;
    assign pixel_count_out = count_q;
    assign frame_done      = done_q;
    assign frame_pixels    = fpix_q;
    assign frame_checksum  = fsum_q;
    assign frame_err_len   = ferr_len_q;
    assign frame_err_sop   = ferr_sop_q;
    assign frames_total    = ftot_q;
    assign drop_count      = drop_q;
endmodule

// File: tb/tb_video_stream_sink.sv
// Scoreboard bench: unit 0 runs READY_MODE=0, unit 1 READY_MODE=1, both 9x7 geometry.
// Stimulus pushes expected frame results; a negedge monitor pops them on frame_done.
module tb_video_stream_sink;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        vld, sop, eop;
    logic [1:0][11:0]  dat;
    logic [1:0]        rdy, fdone, ferl, fers;
    logic [1:0][31:0]  pcnt, fpix;
    logic [1:0][23:0]  fsum;
    logic [1:0][15:0]  ftot, dcnt;

    video_stream_sink #(.IMAGE_WIDTH(9), .IMAGE_HEIGHT(7), .READY_MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .valid_in(vld[0]), .startofpacket_in(sop[0]),
        .endofpacket_in(eop[0]), .data_in(dat[0]), .ready_out(rdy[0]),
        .pixel_count_out(pcnt[0]), .frame_done(fdone[0]), .frame_pixels(fpix[0]),
        .frame_checksum(fsum[0]), .frame_err_len(ferl[0]), .frame_err_sop(fers[0]),
        .frames_total(ftot[0]), .drop_count(dcnt[0]));

    video_stream_sink #(.IMAGE_WIDTH(9), .IMAGE_HEIGHT(7), .READY_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .valid_in(vld[1]), .startofpacket_in(sop[1]),
        .endofpacket_in(eop[1]), .data_in(dat[1]), .ready_out(rdy[1]),
        .pixel_count_out(pcnt[1]), .frame_done(fdone[1]), .frame_pixels(fpix[1]),
        .frame_checksum(fsum[1]), .frame_err_len(ferl[1]), .frame_err_sop(fers[1]),
        .frames_total(ftot[1]), .drop_count(dcnt[1]));

    typedef struct {
        logic [31:0] pixels;
        logic [23:0] sum;
        logic        err_len;
        logic        err_sop;
        logic [15:0] total;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   tot[2] = '{0, 0};
    int   cyc = 0;
    int   beats1 = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (vld[1] && rdy[1]) beats1 <= beats1 + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic check_done(input int u);
        exp_t e;
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            chk($sformatf("u%0d_unexpected_frame_done", u), 32'd1, 32'd0);
            return;
        end
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("u%0d_frame_pixels", u), fpix[u], e.pixels);
        chk($sformatf("u%0d_frame_checksum", u), {8'd0, fsum[u]}, {8'd0, e.sum});
        chk($sformatf("u%0d_frame_err_len", u), {31'd0, ferl[u]}, {31'd0, e.err_len});
        chk($sformatf("u%0d_frame_err_sop", u), {31'd0, fers[u]}, {31'd0, e.err_sop});
        chk($sformatf("u%0d_frames_total", u), {16'd0, ftot[u]}, {16'd0, e.total});
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++)
            if (fdone[u]) check_done(u);
    end

    // While ready is low, present a poison SOP+EOP beat that must never be taken.
    task automatic send(input int u, input logic [11:0] d, input logic s, input logic e);
        int w = 0;
        while (!rdy[u] && w < 8) begin
            vld[u] = 1'b1; sop[u] = 1'b1; eop[u] = 1'b1; dat[u] = 12'hABC;
            @(negedge clk);
            w++;
        end
        if (!rdy[u]) chk($sformatf("u%0d_ready_timeout", u), 32'd0, 32'd1);
        vld[u] = 1'b1; sop[u] = s; eop[u] = e; dat[u] = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int u);
        vld[u] = 1'b0; sop[u] = 1'b0; eop[u] = 1'b0; dat[u] = 12'd0;
    endtask

    function automatic logic [11:0] pix(input int kind, input int i);
        int r = i / 9;
        int c = i % 9;
        if (kind == 0) return (r >= 1 && r <= 5 && c >= 2 && c <= 6) ? 12'hFFF : 12'h000;
        return 12'((i * 37 + 5) & 32'hFFF);
    endfunction

    // kind 0: 5x5 block of 0xFFF in a 9x7 frame (sum 25*0xFFF = 0x018FE7)
    task automatic send_frame(input int u, input int n, input logic eop_last,
                              input int kind, input logic rst_flag);
        exp_t e;
        logic [23:0] s = 24'd0;
        for (int i = 0; i < n; i++) s = s + {12'd0, pix(kind, i)};
        if (eop_last) begin
            tot[u]++;
            e.pixels  = 32'(n);
            e.sum     = (kind == 0) ? 24'h018FE7 : s;
            e.err_len = (n != 63);
            e.err_sop = rst_flag;
            e.total   = 16'(tot[u]);
            if (u == 0) q0.push_back(e); else q1.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            send(u, pix(kind, i), (i == 0), eop_last && (i == n - 1));
            if (u == 0 && kind == 0 && i == 9) chk("u0_pixel_count_mid", pcnt[0], 32'd10);
        end
        idle(u);
    endtask

    initial begin
        int t0, w;
        idle(0); idle(1);
        for (int k = 0; k < 5; k++) begin
            vld = 2'($urandom); sop = 2'($urandom); eop = 2'($urandom);
            dat[0] = 12'($urandom); dat[1] = 12'($urandom);
            @(negedge clk);
            chk("reset_outputs_zero",
                {30'd0, |{rdy, fdone, ferl, fers}, |{pcnt, fpix, fsum, ftot, dcnt}}, 32'd0);
        end
        idle(0); idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("u0_ready_after_release", {31'd0, rdy[0]}, 32'd1);
        chk("u1_ready_first_toggle", {31'd0, rdy[1]}, 32'd1);
        @(negedge clk);
        chk("u1_ready_second_toggle", {31'd0, rdy[1]}, 32'd0);

        send_frame(0, 63, 1'b1, 0, 1'b0);
        chk("u0_pixel_count_after_close", pcnt[0], 32'd0);

        w = 0;
        while (rdy[1] && w < 4) begin @(negedge clk); w++; end
        t0 = cyc;
        beats1 = 0;
        send_frame(1, 63, 1'b1, 0, 1'b0);
        chk("u1_cycles_for_frame", 32'(cyc - t0), 32'd126);
        chk("u1_beats_accepted", 32'(beats1), 32'd63);

        for (int k = 0; k < 4; k++) send(0, 12'h123, 1'b0, 1'b0);
        idle(0);
        @(negedge clk);
        chk("u0_drop_count", {16'd0, dcnt[0]}, 32'd4);

        send_frame(0, 40, 1'b1, 1, 1'b0);
        send_frame(0, 70, 1'b1, 1, 1'b0);

        send_frame(0, 11, 1'b0, 1, 1'b0);
        send(0, pix(1, 0), 1'b1, 1'b0);
        chk("u0_pixel_count_restart", pcnt[0], 32'd1);
        chk("u0_no_done_on_restart", {31'd0, fdone[0]}, 32'd0);
        idle(0);
        begin
            exp_t e;
            logic [23:0] s = 24'd0;
            for (int i = 0; i < 63; i++) s = s + {12'd0, pix(1, i)};
            tot[0]++;
            e.pixels = 32'd63; e.sum = s; e.err_len = 1'b0; e.err_sop = 1'b1;
            e.total = 16'(tot[0]);
            q0.push_back(e);
            for (int i = 1; i < 63; i++) send(0, pix(1, i), 1'b0, (i == 62));
            idle(0);
        end
        chk("u0_drop_count_held", {16'd0, dcnt[0]}, 32'd4);

        send_frame(0, 30, 1'b0, 1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_pixel_count", pcnt[0], 32'd0);
        chk("async_reset_totals", {ftot[0], dcnt[0]}, 32'd0);
        chk("async_reset_frame_pixels", fpix[0], 32'd0);
        chk("async_reset_ready", {31'd0, rdy[0]}, 32'd0);
        tot[0] = 0; tot[1] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(0, 63, 1'b1, 0, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_u0_drained", 32'(q0.size()), 32'd0);
        chk("scoreboard_u1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
